stream_crossbar: RTL and testbench

Packet-aware AXI-Stream-style crossbar. It routes `S_DATA_COUNT` source streams to `M_DATA_COUNT` sink streams by a per-beat destination index. Each sink has its own round-robin arbiter that locks onto a source for a whole packet. It sits between stream producers and consumers as the on-chip switch fabric; the data path is combinational and only the arbitration state is registered.

---
 rtl/stream_crossbar.sv | 95 +++++++++
 tb/tb_stream_crossbar.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/stream_crossbar.sv
// Packet-aware stream crossbar with a per-sink round-robin arbiter; STREAM_CROSSBAR_BEAT_ARB_EN selects per-beat arbitration.
// Zero-cycle data path; s_ready follows the granted sink's m_ready combinationally, only grant/lock state is registered.
module stream_crossbar #(
  parameter int T_DATA_WIDTH = 8,
  parameter int S_DATA_COUNT = 2,
  parameter int M_DATA_COUNT = 2,
  localparam int DW = (M_DATA_COUNT > 1) ? $clog2(M_DATA_COUNT) : 1,
  localparam int IW = (S_DATA_COUNT > 1) ? $clog2(S_DATA_COUNT) : 1
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic [S_DATA_COUNT-1:0][T_DATA_WIDTH-1:0]   s_data_i,
  input  logic [S_DATA_COUNT-1:0][DW-1:0]             s_dest_i,
  input  logic [S_DATA_COUNT-1:0]                     s_last_i,
  input  logic [S_DATA_COUNT-1:0]                     s_valid_i,
  output logic [S_DATA_COUNT-1:0]                     s_ready_o,
  output logic [M_DATA_COUNT-1:0][T_DATA_WIDTH-1:0]   m_data_o,
  output logic [M_DATA_COUNT-1:0][IW-1:0]             m_id_o,
  output logic [M_DATA_COUNT-1:0]                     m_last_o,
  output logic [M_DATA_COUNT-1:0]                     m_valid_o,
  input  logic [M_DATA_COUNT-1:0]                     m_ready_i
);

  logic [M_DATA_COUNT-1:0]         locked;
  logic [M_DATA_COUNT-1:0][IW-1:0] owner;
  logic [M_DATA_COUNT-1:0][IW-1:0] last_grant;
  logic [M_DATA_COUNT-1:0]         gnt_vld;
  logic [M_DATA_COUNT-1:0][IW-1:0] gnt_idx;

  always_comb begin
    int          idx_i;
    logic [IW-1:0] idx;
    logic [IW-1:0] g;
    logic        sel;
    gnt_vld   = '0;
    gnt_idx   = '0;
    m_data_o  = '0;
    m_id_o    = '0;
    m_last_o  = '0;
    m_valid_o = '0;
    s_ready_o = '0;
    idx_i     = 0;
    idx       = '0;
    g         = '0;
    sel       = 1'b0;
    for (int m = 0; m < M_DATA_COUNT; m++) begin
      if (locked[m]) begin
        gnt_vld[m] = 1'b1;
        gnt_idx[m] = owner[m];
      end else begin
        // Search starts just after the previous winner so it drops to lowest priority.
        for (int k = 1; k <= S_DATA_COUNT; k++) begin
          idx_i = (int'(last_grant[m]) + k) % S_DATA_COUNT;
          idx   = IW'(idx_i);
          if (!gnt_vld[m] && s_valid_i[idx] && (s_dest_i[idx] == DW'(m))) begin
            gnt_vld[m] = 1'b1;
            gnt_idx[m] = idx;
          end
        end
      end
      if (gnt_vld[m] && !rst) begin
        g            = gnt_idx[m];
        sel          = (s_dest_i[g] == DW'(m));
        m_valid_o[m] = s_valid_i[g] && sel;
        m_data_o[m]  = s_data_i[g];
        m_last_o[m]  = s_last_i[g];
        m_id_o[m]    = g;
        if (sel && m_ready_i[m]) s_ready_o[g] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      locked <= '0;
      for (int m = 0; m < M_DATA_COUNT; m++) begin
        owner[m]      <= '0;
        last_grant[m] <= IW'(S_DATA_COUNT - 1);
      end
    end else begin
      for (int m = 0; m < M_DATA_COUNT; m++) begin
        if (m_valid_o[m] && m_ready_i[m]) begin
          last_grant[m] <= gnt_idx[m];
          owner[m]      <= gnt_idx[m];
`ifdef STREAM_CROSSBAR_BEAT_ARB_EN
          locked[m]     <= 1'b0;
`else
          locked[m]     <= !m_last_o[m];
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_stream_crossbar.sv
// Directed-vector bench for stream_crossbar (T=4, S=M=2); sink beats are checked by a queue-based monitor.
module tb_stream_crossbar;
  logic            clk = 1'b0;
  logic            rst;
  logic [1:0][3:0] s_data;
  logic [1:0][0:0] s_dest;
  logic [1:0]      s_last, s_valid, s_ready;
  logic [1:0][3:0] m_data;
  logic [1:0][0:0] m_id;
  logic [1:0]      m_last, m_valid, m_ready;

  int checks = 0;
  int errors = 0;
  logic [5:0] q0[$];
  logic [5:0] q1[$];
  logic [5:0] e0, e1;

  stream_crossbar #(.T_DATA_WIDTH(4), .S_DATA_COUNT(2), .M_DATA_COUNT(2)) dut (
    .clk(clk), .rst(rst),
    .s_data_i(s_data), .s_dest_i(s_dest), .s_last_i(s_last),
    .s_valid_i(s_valid), .s_ready_o(s_ready),
    .m_data_o(m_data), .m_id_o(m_id), .m_last_o(m_last),
    .m_valid_o(m_valid), .m_ready_i(m_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // dst/lst bit i belongs to source i; id0/id1 are the expected sources on sinks 0/1.
  task automatic apply(input logic r, input logic [1:0] mr, input logic [1:0] val,
                       input logic [1:0] dst, input logic [1:0] lst,
                       input logic [3:0] d0, input logic [3:0] d1,
                       input logic [1:0] esr, input logic [1:0] emv,
                       input logic id0, input logic id1);
    rst       = r;
    m_ready   = mr;
    s_valid   = val;
    s_dest[0] = dst[0];
    s_dest[1] = dst[1];
    s_last    = lst;
    s_data[0] = d0;
    s_data[1] = d1;
    if (emv[0] && mr[0]) q0.push_back({id0 ? d1 : d0, id0, lst[id0]});
    if (emv[1] && mr[1]) q1.push_back({id1 ? d1 : d0, id1, lst[id1]});
    @(negedge clk);
    check("s_ready", {6'd0, s_ready}, {6'd0, esr});
    check("m_valid", {6'd0, m_valid}, {6'd0, emv});
    if (emv[0]) begin
      check("m0_data", {4'd0, m_data[0]}, {4'd0, id0 ? d1 : d0});
      check("m0_id", {7'd0, m_id[0]}, {7'd0, id0});
    end
    if (emv[1]) begin
      check("m1_data", {4'd0, m_data[1]}, {4'd0, id1 ? d1 : d0});
      check("m1_id", {7'd0, m_id[1]}, {7'd0, id1});
    end
    if (r) begin
      check("rst_data", m_data, 8'd0);
      check("rst_id_last", {4'd0, m_id, m_last}, 8'd0);
    end
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (m_valid[0] && m_ready[0]) begin
      checks++;
      if (q0.size() == 0) begin
        errors++;
        $display("FAIL m0_beat actual=%h required=none", {m_data[0], m_id[0], m_last[0]});
      end else begin
        e0 = q0.pop_front();
        if ({m_data[0], m_id[0], m_last[0]} !== e0) begin
          errors++;
          $display("FAIL m0_beat actual=%h required=%h", {m_data[0], m_id[0], m_last[0]}, e0);
        end
      end
    end
    if (m_valid[1] && m_ready[1]) begin
      checks++;
      if (q1.size() == 0) begin
        errors++;
        $display("FAIL m1_beat actual=%h required=none", {m_data[1], m_id[1], m_last[1]});
      end else begin
        e1 = q1.pop_front();
        if ({m_data[1], m_id[1], m_last[1]} !== e1) begin
          errors++;
          $display("FAIL m1_beat actual=%h required=%h", {m_data[1], m_id[1], m_last[1]}, e1);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; m_ready = 2'b11; s_valid = 2'b00; s_dest = '0; s_last = 2'b00; s_data = '0;
    @(posedge clk);
    #1;
    // reset state: requests present but everything held off
    apply(1, 2'b11, 2'b11, 2'b00, 2'b11, 4'h1, 4'h2, 2'b00, 2'b00, 0, 0);
    // independent routing
    apply(0, 2'b11, 2'b11, 2'b10, 2'b11, 4'h3, 4'hA, 2'b11, 2'b11, 0, 1);
    // contention after reset: src0 first, then alternate
    apply(1, 2'b11, 2'b11, 2'b00, 2'b11, 4'h5, 4'h6, 2'b00, 2'b00, 0, 0);
    apply(0, 2'b11, 2'b11, 2'b00, 2'b11, 4'h5, 4'h6, 2'b01, 2'b01, 0, 0);
    apply(0, 2'b11, 2'b11, 2'b00, 2'b11, 4'h5, 4'h6, 2'b10, 2'b01, 1, 0);
    apply(0, 2'b11, 2'b11, 2'b00, 2'b11, 4'h5, 4'h6, 2'b01, 2'b01, 0, 0);
    // src1 3-beat packet on sink 0 while src0 competes
`ifdef STREAM_CROSSBAR_BEAT_ARB_EN
    apply(0, 2'b11, 2'b11, 2'b00, 2'b01, 4'hC, 4'h1, 2'b10, 2'b01, 1, 0);
    apply(0, 2'b11, 2'b11, 2'b00, 2'b01, 4'hC, 4'h2, 2'b01, 2'b01, 0, 0);
    apply(0, 2'b11, 2'b11, 2'b00, 2'b01, 4'hD, 4'h2, 2'b10, 2'b01, 1, 0);
    apply(0, 2'b11, 2'b11, 2'b00, 2'b11, 4'hD, 4'h3, 2'b01, 2'b01, 0, 0);
    apply(0, 2'b11, 2'b10, 2'b00, 2'b10, 4'h0, 4'h3, 2'b10, 2'b01, 1, 0);
`else
    apply(0, 2'b11, 2'b11, 2'b00, 2'b01, 4'hC, 4'h1, 2'b10, 2'b01, 1, 0);
    apply(0, 2'b11, 2'b11, 2'b00, 2'b01, 4'hC, 4'h2, 2'b10, 2'b01, 1, 0);
    apply(0, 2'b11, 2'b11, 2'b00, 2'b11, 4'hC, 4'h3, 2'b10, 2'b01, 1, 0);
    apply(0, 2'b11, 2'b01, 2'b00, 2'b01, 4'hC, 4'h0, 2'b01, 2'b01, 0, 0);
    apply(0, 2'b11, 2'b01, 2'b00, 2'b01, 4'hD, 4'h0, 2'b01, 2'b01, 0, 0);
`endif
    // backpressure: valid stays up and stable, nothing accepted
    apply(0, 2'b00, 2'b11, 2'b01, 2'b11, 4'h7, 4'h9, 2'b00, 2'b11, 1, 0);
    apply(0, 2'b00, 2'b11, 2'b01, 2'b11, 4'h7, 4'h9, 2'b00, 2'b11, 1, 0);
    apply(0, 2'b11, 2'b11, 2'b01, 2'b11, 4'h7, 4'h9, 2'b11, 2'b11, 1, 0);
    // reset mid-packet: src0 opens a packet on sink 1, reset drops the lock
    apply(0, 2'b11, 2'b01, 2'b01, 2'b00, 4'h4, 4'h0, 2'b01, 2'b10, 0, 0);
    apply(1, 2'b11, 2'b11, 2'b11, 2'b10, 4'h5, 4'h8, 2'b00, 2'b00, 0, 0);
    apply(0, 2'b11, 2'b10, 2'b11, 2'b10, 4'h5, 4'h8, 2'b10, 2'b10, 0, 1);
    apply(0, 2'b11, 2'b01, 2'b11, 2'b01, 4'h6, 4'h0, 2'b01, 2'b10, 0, 0);
    apply(0, 2'b11, 2'b00, 2'b00, 2'b00, 4'h0, 4'h0, 2'b00, 2'b00, 0, 0);
    check("q0_drained", 8'(q0.size()), 8'd0);
    check("q1_drained", 8'(q1.size()), 8'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
